// File: rtl/rast_perf_watch_if.sv
// Bus bundle for rast_perf_watch.
// Carries the run-control strobes, event taps, watchdog controls and the
// indexed read port between the rasterizer-side logic and the monitor.
//   master : drives control/event/read-request signals, receives results
//   slave  : the monitor itself
interface rast_perf_watch_if #(
  parameter int NUM_EVT = 6,
  parameter int CYC_W   = 40,
  parameter int WDOG_W  = 26
);
  localparam int IDX_W = $clog2(NUM_EVT + 2);

  logic                 start_H;
  logic                 stop_H;
  logic [NUM_EVT-1:0]   evt_H;
  logic                 halt_RnnnnL;
  logic                 progress_H;
  logic [WDOG_W-1:0]    wdog_limit_U;
  logic                 rd_req_H;
  logic [IDX_W-1:0]     rd_idx_U;
  logic [CYC_W-1:0]     rd_data_U;
  logic                 rd_valid_H;
  logic [1:0]           state_U;
  logic                 done_H;
  logic                 timeout_H;
  logic [NUM_EVT+1:0]   overflow_H;

  modport master (
    output start_H, stop_H, evt_H, halt_RnnnnL, progress_H, wdog_limit_U,
           rd_req_H, rd_idx_U,
    input  rd_data_U, rd_valid_H, state_U, done_H, timeout_H, overflow_H
  );

  modport slave (
    input  start_H, stop_H, evt_H, halt_RnnnnL, progress_H, wdog_limit_U,
           rd_req_H, rd_idx_U,
    output rd_data_U, rd_valid_H, state_U, done_H, timeout_H, overflow_H
  );
endinterface

// File: rtl/rast_perf_watch.sv
// Performance monitor and progress watchdog for the rasterizer pipeline.
// Counts NUM_EVT single-bit event channels plus run cycles and halt-stall
// cycles with saturating counters, runs a drain window after stop, and
// offers a one-cycle-latency indexed read of the (live or frozen) counters.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-low reset
//   bus  : rast_perf_watch_if slave modport
//          start_H/stop_H run control, evt_H event taps, halt_RnnnnL stall
//          (low = stall), progress_H watchdog kick, wdog_limit_U idle limit
//          (0 = off), rd_req_H/rd_idx_U read request, rd_data_U/rd_valid_H
//          read response, state_U/done_H/timeout_H/overflow_H status
module rast_perf_watch #(
  parameter int NUM_EVT = 6,
  parameter int CNT_W   = 32,
  parameter int CYC_W   = 40,
  parameter int DRAIN   = 15,
  parameter int WDOG_W  = 26
) (
  input  logic              clk,
  input  logic              rst,
  rast_perf_watch_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_EVT + 2);
  localparam int NCNT  = NUM_EVT + 2;
  localparam int DW    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN > 0) ? DRAIN - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN_ST = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    evt_cnt_q [NUM_EVT];
  logic [CNT_W-1:0]    evt_cnt_d [NUM_EVT];
  logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [CYC_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [WDOG_W-1:0]   wdog_inc;
  logic                timeout_q, timeout_d;
  logic [NCNT-1:0]     ovf_q, ovf_d;
  logic                rd_valid_q, rd_valid_d;
  logic [CYC_W-1:0]    rd_data_q, rd_data_d;
  logic                counting;

  always_comb begin
    state_d     = state_q;
    evt_cnt_d   = evt_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    drain_d     = drain_q;
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
    ovf_d       = ovf_q;
    counting    = 1'b0;
    wdog_inc    = wdog_q + WDOG_W'(1);

    if (bus.start_H) begin
      // Start wins over everything, in every state; the start cycle itself
      // is not counted.
      state_d     = RUN;
      for (int unsigned i = 0; i < NUM_EVT; i++) begin
        evt_cnt_d[i] = '0;
      end
      cyc_cnt_d   = '0;
      stall_cnt_d = '0;
      drain_d     = '0;
      wdog_d      = '0;
      timeout_d   = 1'b0;
      ovf_d       = '0;
    end else begin
      counting = (state_q == RUN) || (state_q == DRAIN_ST);

      if (counting) begin
        for (int unsigned i = 0; i < NUM_EVT; i++) begin
          if (bus.evt_H[i]) begin
            if (evt_cnt_q[i] == '1) begin
              ovf_d[i] = 1'b1;
            end else begin
              evt_cnt_d[i] = evt_cnt_q[i] + CNT_W'(1);
            end
          end
        end
        if (cyc_cnt_q == '1) begin
          ovf_d[NUM_EVT] = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
        if (!bus.halt_RnnnnL) begin
          if (stall_cnt_q == '1) begin
            ovf_d[NUM_EVT+1] = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + CYC_W'(1);
          end
        end
      end

      // Watchdog only advances while in RUN; any exit clears it.
      wdog_d = '0;
      case (state_q)
        RUN: begin
          if (!bus.progress_H && (bus.wdog_limit_U != '0) &&
              (wdog_inc == bus.wdog_limit_U)) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else if (bus.stop_H) begin
            if (DRAIN == 0) begin
              state_d = DONE;
            end else begin
              state_d = DRAIN_ST;
              drain_d = DRAIN_LOAD;
            end
          end else begin
            wdog_d = bus.progress_H ? '0 : wdog_inc;
          end
        end
        DRAIN_ST: begin
          if (drain_q == '0) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
        default: ;
      endcase
    end

    // Read returns the pre-update counter values, so a request issued the
    // cycle after an event already sees it.
    rd_valid_d = bus.rd_req_H;
    rd_data_d  = rd_data_q;
    if (bus.rd_req_H) begin
      rd_data_d = '0;
      for (int unsigned i = 0; i < NUM_EVT; i++) begin
        if (bus.rd_idx_U == IDX_W'(i)) begin
          rd_data_d = CYC_W'(evt_cnt_q[i]);
        end
      end
      if (bus.rd_idx_U == IDX_W'(NUM_EVT)) begin
        rd_data_d = cyc_cnt_q;
      end
      if (bus.rd_idx_U == IDX_W'(NUM_EVT + 1)) begin
        rd_data_d = stall_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < NUM_EVT; i++) begin
        evt_cnt_q[i] <= '0;
      end
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      drain_q     <= '0;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
      ovf_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      evt_cnt_q   <= evt_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      drain_q     <= drain_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bus.state_U    = state_q;
  assign bus.done_H     = (state_q == DONE);
  assign bus.timeout_H  = timeout_q;
  assign bus.overflow_H = ovf_q;
  assign bus.rd_valid_H = rd_valid_q;
  assign bus.rd_data_U  = rd_data_q;

endmodule

// File: tb/tb_rast_perf_watch.sv
// Bench for rast_perf_watch: two instances share one stimulus stream.
//   A: default parameters.
//   B: NUM_EVT=5, CNT_W=4, CYC_W=8, DRAIN=0 (saturation, direct stop->DONE,
//      representable out-of-range read index).
module tb_rast_perf_watch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, halt = 1'b1, progress = 1'b0;
  logic [5:0]  evt = '0;
  logic [25:0] wlimit = '0;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_idx = '0;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  rast_perf_watch_if #(.NUM_EVT(6), .CYC_W(40), .WDOG_W(26)) ifa ();
  rast_perf_watch_if #(.NUM_EVT(5), .CYC_W(8),  .WDOG_W(26)) ifb ();

  assign ifa.start_H = start;       assign ifb.start_H = start;
  assign ifa.stop_H = stop;         assign ifb.stop_H = stop;
  assign ifa.evt_H = evt;           assign ifb.evt_H = evt[4:0];
  assign ifa.halt_RnnnnL = halt;    assign ifb.halt_RnnnnL = halt;
  assign ifa.progress_H = progress; assign ifb.progress_H = progress;
  assign ifa.wdog_limit_U = wlimit; assign ifb.wdog_limit_U = wlimit;
  assign ifa.rd_req_H = rd_req;     assign ifb.rd_req_H = rd_req;
  assign ifa.rd_idx_U = rd_idx;     assign ifb.rd_idx_U = rd_idx;

  rast_perf_watch #(.NUM_EVT(6), .CNT_W(32), .CYC_W(40), .DRAIN(15), .WDOG_W(26))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rast_perf_watch #(.NUM_EVT(5), .CNT_W(4), .CYC_W(8), .DRAIN(0), .WDOG_W(26))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Reference model: counters indexed 0..n-1 events, n cycles, n+1 stalls.
  // States: 0 idle, 1 run, 2 drain, 3 done.
  int              ne   [2] = '{6, 5};
  longint unsigned emax [2] = '{64'hFFFF_FFFF, 64'd15};
  longint unsigned cmax [2] = '{64'hFF_FFFF_FFFF, 64'd255};
  int              drn  [2] = '{15, 0};

  int              mst  [2];
  longint unsigned mcnt [2][8];
  int              mleft[2];
  longint unsigned midle[2];
  bit              mto  [2];
  logic [7:0]      movf [2];
  bit              mrv  [2];
  longint unsigned mrd  [2];

  task automatic bump(input int d, input int k, input longint unsigned mx);
    if (mcnt[d][k] == mx) movf[d][k] = 1'b1;
    else mcnt[d][k] = mcnt[d][k] + 1;
  endtask

  task automatic model_clear(input int d);
    for (int k = 0; k < 8; k++) mcnt[d][k] = 0;
    movf[d] = '0;
    mto[d] = 1'b0;
    midle[d] = 0;
    mleft[d] = 0;
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int n;
      n = ne[d];
      if (!rst) begin
        model_clear(d);
        mst[d] = 0;
        mrv[d] = 1'b0;
        mrd[d] = 0;
      end else begin
        mrv[d] = rd_req;
        if (rd_req) mrd[d] = (int'(rd_idx) < n + 2) ? mcnt[d][rd_idx] : 0;
        if (start) begin
          model_clear(d);
          mst[d] = 1;
        end else if (mst[d] == 1 || mst[d] == 2) begin
          for (int k = 0; k < n; k++) if (evt[k]) bump(d, k, emax[d]);
          bump(d, n, cmax[d]);
          if (!halt) bump(d, n + 1, cmax[d]);
          if (mst[d] == 1) begin
            midle[d] = progress ? 0 : midle[d] + 1;
            if (wlimit != 0 && midle[d] == longint'(wlimit)) begin
              mto[d] = 1'b1;
              mst[d] = 3;
              midle[d] = 0;
            end else if (stop) begin
              midle[d] = 0;
              if (drn[d] == 0) mst[d] = 3;
              else begin
                mst[d] = 2;
                mleft[d] = drn[d] - 1;
              end
            end
          end else begin
            if (mleft[d] == 0) mst[d] = 3;
            else mleft[d] = mleft[d] - 1;
          end
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      mst[d] = 0;
      mrv[d] = 1'b0;
      mrd[d] = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("a_state",   longint'(ifa.state_U),    longint'(mst[0]));
        chk("a_done",    longint'(ifa.done_H),     longint'(mst[0] == 3));
        chk("a_timeout", longint'(ifa.timeout_H),  longint'(mto[0]));
        chk("a_ovf",     longint'(ifa.overflow_H), longint'(movf[0]));
        chk("a_rvalid",  longint'(ifa.rd_valid_H), longint'(mrv[0]));
        chk("a_rdata",   longint'(ifa.rd_data_U),  mrd[0]);
        chk("b_state",   longint'(ifb.state_U),    longint'(mst[1]));
        chk("b_done",    longint'(ifb.done_H),     longint'(mst[1] == 3));
        chk("b_timeout", longint'(ifb.timeout_H),  longint'(mto[1]));
        chk("b_ovf",     longint'(ifb.overflow_H), longint'(movf[1]));
        chk("b_rvalid",  longint'(ifb.rd_valid_H), longint'(mrv[1]));
        chk("b_rdata",   longint'(ifb.rd_data_U),  mrd[1]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int idx);
    rd_req = 1'b1;
    rd_idx = 3'(idx);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b1;
    chk("reset_state_a", longint'(ifa.state_U), 0);
    chk("reset_rvalid_a", longint'(ifa.rd_valid_H), 0);
    chk("reset_rdata_a", longint'(ifa.rd_data_U), 0);
    tick();

    // Start and stop together in IDLE: start wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle_a", longint'(ifa.state_U), 1);
    chk("start_stop_idle_b", longint'(ifb.state_U), 1);

    // Basic run: 100 run cycles (stop on the last), 15 drain cycles
    pulse_start();
    for (int i = 0; i < 115; i++) begin
      evt[0] = 1'b1;
      evt[1] = (i % 4 == 0);
      stop = (i == 99);
      tick();
      if (i == 99) begin
        chk("drain_entry_a", longint'(ifa.state_U), 2);
        chk("drain0_done_b", longint'(ifb.state_U), 3);
      end
      if (i == 113) chk("drain_last_a", longint'(ifa.state_U), 2);
    end
    evt = '0; stop = 1'b0;
    chk("done_state_a", longint'(ifa.state_U), 3);
    chk("done_flag_a", longint'(ifa.done_H), 1);
    rd(0); chk("ch0_a", ifa.rd_data_U, 115); chk("ch0_sat_b", longint'(ifb.rd_data_U), 15);
    rd(1); chk("ch1_a", ifa.rd_data_U, 29);
    rd(6); chk("cyc_a", ifa.rd_data_U, 115);
    rd(5); chk("cyc_b", longint'(ifb.rd_data_U), 100);
    chk("ovf0_b", longint'(ifb.overflow_H[0]), 1);

    // Back-to-back reads of every index
    for (int k = 0; k < 8; k++) begin
      rd_req = 1'b1;
      rd_idx = 3'(k);
      tick();
    end
    chk("oor_data_b", longint'(ifb.rd_data_U), 0);
    chk("oor_valid_b", longint'(ifb.rd_valid_H), 1);
    rd_req = 1'b0;
    tick();

    // Stalls
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      halt = !(i >= 5 && i < 25);
      stop = (i == 29);
      tick();
    end
    halt = 1'b1; stop = 1'b0;
    repeat (16) tick();
    rd(7); chk("stall_a", ifa.rd_data_U, 20);
    rd(6); chk("cyc_stall_a", ifa.rd_data_U, 45); chk("stall_b", longint'(ifb.rd_data_U), 20);

    // Watchdog fires 50 cycles after start with no progress
    wlimit = 26'd50;
    pulse_start();
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 49) begin
        chk("wdog_pre_to_a", longint'(ifa.timeout_H), 0);
        chk("wdog_pre_st_a", longint'(ifa.state_U), 1);
      end
      if (k == 50) begin
        chk("wdog_to_a", longint'(ifa.timeout_H), 1);
        chk("wdog_st_a", longint'(ifa.state_U), 3);
      end
    end
    rd(6); chk("wdog_cyc_a", ifa.rd_data_U, 50);
    rd(5); chk("wdog_cyc_b", longint'(ifb.rd_data_U), 50);

    // Kicks every 40 cycles keep it alive
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      progress = (i % 40 == 39);
      tick();
    end
    progress = 1'b0;
    chk("kick_to_a", longint'(ifa.timeout_H), 0);
    chk("kick_st_a", longint'(ifa.state_U), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (20) tick();
    wlimit = '0;

    // Saturation on channel 2, then cleared by start
    pulse_start();
    evt[2] = 1'b1;
    repeat (20) tick();
    evt = '0;
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (20) tick();
    rd(2); chk("sat_ch2_b", longint'(ifb.rd_data_U), 15); chk("ch2_a", ifa.rd_data_U, 20);
    chk("sat_ovf2_b", longint'(ifb.overflow_H[2]), 1);
    pulse_start();
    chk("start_clr_ovf_b", longint'(ifb.overflow_H), 0);
    rd(2); chk("start_clr_ch2_b", longint'(ifb.rd_data_U), 0);

    // Start during drain restarts
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (3) tick();
    chk("in_drain_a", longint'(ifa.state_U), 2);
    pulse_start();
    chk("restart_st_a", longint'(ifa.state_U), 1);
    rd(6); chk("restart_cyc_a", ifa.rd_data_U, 0);

    // Reset mid-run
    evt = 6'h3F;
    repeat (5) tick();
    evt = '0;
    rd(6);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mid_rst_st_a", longint'(ifa.state_U), 0);
    chk("mid_rst_rdata_a", longint'(ifa.rd_data_U), 0);
    chk("mid_rst_rvalid_a", longint'(ifa.rd_valid_H), 0);
    chk("mid_rst_done_a", longint'(ifa.done_H), 0);

    // Randomized traffic
    wlimit = 26'($urandom_range(20, 80));
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 499) != 0);
      evt      = 6'($urandom);
      halt     = ($urandom_range(0, 3) != 0);
      progress = ($urandom_range(0, 15) == 0);
      start    = ($urandom_range(0, 199) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      rd_req   = 1'($urandom_range(0, 1));
      rd_idx   = 3'($urandom);
      tick();
    end
    rst = 1'b1; start = 1'b0; stop = 1'b0; rd_req = 1'b0; evt = '0;
    tick();
    @(negedge clk);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
